output_dispatcher: RTL and testbench

OUTPUT_DISPATCHER -- requirements
Module: output_dispatcher

---
 rtl/output_dispatcher_pkg.sv | 14 +
 rtl/small_fifo.sv | 58 +++++
 rtl/output_dispatcher.sv | 155 +++++++++++++++
 tb/tb_output_dispatcher.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/output_dispatcher_pkg.sv
// Shared defines for the output dispatcher: FSM encoding and module-header constants.
package output_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WR_PKT = 2'd2,
    ST_DROP   = 2'd3
  } state_e;

  localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hFF;
  localparam int         DST_FIELD_LSB_DEF  = 48;

endpackage

// File: rtl/small_fifo.sv
// Small synchronous FIFO with registered read port: dout updates the cycle after rd_en.
module small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 5,
  parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);
  localparam int DEPTH = 2**MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] NF_C = NEARLY_FULL[MAX_DEPTH_BITS:0];

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]          dout_q, dout_d;
  logic                      do_wr, do_rd, full;

  always_comb begin
    full     = cnt_q[MAX_DEPTH_BITS];
    do_rd    = rd_en && (cnt_q != '0);
    // a read in the same cycle frees the slot, so a write into a full FIFO is still taken
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + MAX_DEPTH_BITS'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + MAX_DEPTH_BITS'(1) : rd_ptr_q;
    cnt_d    = cnt_q + (MAX_DEPTH_BITS+1)'(do_wr) - (MAX_DEPTH_BITS+1)'(do_rd);
    dout_d   = do_rd ? mem[rd_ptr_q] : dout_q;
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  assign dout        = dout_q;
  assign empty       = (cnt_q == '0);
  assign nearly_full = (cnt_q >= NF_C);

endmodule

// File: rtl/output_dispatcher.sv
// Routes packets from one input stream to a multicast set of 4 output ports using the DST header bitmap.
// Optional OUTPUT_DISPATCHER_STRIP_HDR_EN: consume the DST header instead of forwarding it.
module output_dispatcher import output_dispatcher_pkg::*; #(
  parameter int                    DATA_WIDTH    = 64,
  parameter int                    CTRL_WIDTH    = DATA_WIDTH/8,
  parameter int                    NUM_QUEUES    = 4,
  parameter logic [CTRL_WIDTH-1:0] DST_HDR_CTRL  = CTRL_WIDTH'(IO_QUEUE_STAGE_NUM),
  parameter int                    DST_FIELD_LSB = DST_FIELD_LSB_DEF
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data_0,
  output logic [CTRL_WIDTH-1:0] out_ctrl_0,
  output logic                  out_wr_0,
  input  logic                  out_rdy_0,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic [CTRL_WIDTH-1:0] out_ctrl_1,
  output logic                  out_wr_1,
  input  logic                  out_rdy_1,
  output logic [DATA_WIDTH-1:0] out_data_2,
  output logic [CTRL_WIDTH-1:0] out_ctrl_2,
  output logic                  out_wr_2,
  input  logic                  out_rdy_2,
  output logic [DATA_WIDTH-1:0] out_data_3,
  output logic [CTRL_WIDTH-1:0] out_ctrl_3,
  output logic                  out_wr_3,
  input  logic                  out_rdy_3,
  output logic [31:0]           drop_count
);
  logic [DATA_WIDTH+CTRL_WIDTH-1:0] f_dout;
  logic [DATA_WIDTH-1:0]            f_data;
  logic [CTRL_WIDTH-1:0]            f_ctrl;
  logic                             f_empty, f_nf, rd_en;

  small_fifo #(.WIDTH(DATA_WIDTH+CTRL_WIDTH), .MAX_DEPTH_BITS(5)) u_fifo (
    .clk(clk), .reset(reset),
    .din({in_ctrl, in_data}), .wr_en(in_wr), .rd_en(rd_en),
    .dout(f_dout), .nearly_full(f_nf), .empty(f_empty)
  );

  assign {f_ctrl, f_data} = f_dout;
  assign in_rdy = reset && !f_nf;

  state_e                 state_q, state_d;
  logic [NUM_QUEUES-1:0]  dst_mask_q, dst_mask_d, wr_q, wr_d, rdy;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [CTRL_WIDTH-1:0]  ctrl_q, ctrl_d;
  logic [31:0]            drop_cnt_q, drop_cnt_d;
  logic                   pend_vld_q, pend_vld_d, prev_zero_q, prev_zero_d;
  logic                   cur_eop, gate, consume, emit;

  assign rdy = {out_rdy_3, out_rdy_2, out_rdy_1, out_rdy_0};

  always_comb begin
    state_d     = state_q;
    dst_mask_d  = dst_mask_q;
    drop_cnt_d  = drop_cnt_q;
    pend_vld_d  = pend_vld_q;
    prev_zero_d = prev_zero_q;
    rd_en       = 1'b0;
    consume     = 1'b0;
    emit        = 1'b0;
    // pend_vld marks that the FIFO output register holds the word currently being processed
    cur_eop     = (f_ctrl != '0) && prev_zero_q;
    gate        = &(rdy | ~dst_mask_q);
    case (state_q)
      ST_IDLE: begin
        pend_vld_d = 1'b0;
        if (!f_empty) begin
          rd_en   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (f_ctrl == DST_HDR_CTRL && f_data[DST_FIELD_LSB +: NUM_QUEUES] != '0) begin
          dst_mask_d = f_data[DST_FIELD_LSB +: NUM_QUEUES];
          state_d    = ST_WR_PKT;
`ifdef OUTPUT_DISPATCHER_STRIP_HDR_EN
          prev_zero_d = (f_ctrl == '0);
          rd_en       = !f_empty;
          pend_vld_d  = !f_empty;
`else
          prev_zero_d = 1'b0;
          pend_vld_d  = 1'b1;
`endif
        end else begin
          state_d     = ST_DROP;
          drop_cnt_d  = (drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + 32'd1;
          prev_zero_d = (f_ctrl == '0);
          rd_en       = !f_empty;
          pend_vld_d  = !f_empty;
        end
      end
      ST_WR_PKT, ST_DROP: begin
        consume = pend_vld_q && (state_q == ST_DROP || gate);
        emit    = consume && (state_q == ST_WR_PKT);
        if (consume) begin
          if (cur_eop) begin
            state_d    = ST_IDLE;
            pend_vld_d = 1'b0;
          end else begin
            prev_zero_d = (f_ctrl == '0);
            rd_en       = !f_empty;
            pend_vld_d  = !f_empty;
          end
        end else if (!pend_vld_q && !f_empty) begin
          rd_en      = 1'b1;
          pend_vld_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    wr_d   = emit ? dst_mask_q : '0;
    data_d = emit ? f_data : data_q;
    ctrl_d = emit ? f_ctrl : ctrl_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      dst_mask_q  <= '0;
      drop_cnt_q  <= '0;
      pend_vld_q  <= 1'b0;
      prev_zero_q <= 1'b0;
      wr_q        <= '0;
      data_q      <= '0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      dst_mask_q  <= dst_mask_d;
      drop_cnt_q  <= drop_cnt_d;
      pend_vld_q  <= pend_vld_d;
      prev_zero_q <= prev_zero_d;
      wr_q        <= wr_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign {out_wr_3, out_wr_2, out_wr_1, out_wr_0} = wr_q;
  assign out_data_0 = data_q;
  assign out_data_1 = data_q;
  assign out_data_2 = data_q;
  assign out_data_3 = data_q;
  assign out_ctrl_0 = ctrl_q;
  assign out_ctrl_1 = ctrl_q;
  assign out_ctrl_2 = ctrl_q;
  assign out_ctrl_3 = ctrl_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_output_dispatcher.sv
// Directed bench for output_dispatcher: packet-level model predicts the global beat sequence.
module tb_output_dispatcher;
`ifdef OUTPUT_DISPATCHER_STRIP_HDR_EN
  localparam int FIRST = 1;
  localparam logic [63:0] FIRST_P2 = 64'h01B0D1E5_00000001;
`else
  localparam int FIRST = 0;
  localparam logic [63:0] FIRST_P2 = 64'h0004_0000_0000_0001;
`endif

  typedef struct {
    logic [3:0]  m;
    logic [63:0] d;
    logic [7:0]  c;
  } beat_t;

  logic        clk = 1'b0, reset = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] od0, od1, od2, od3;
  logic [7:0]  oc0, oc1, oc2, oc3;
  logic        ow0, ow1, ow2, ow3;
  logic [3:0]  out_rdy = 4'hF;
  logic [31:0] drop_count;

  int checks = 0, failures = 0, cyc = 0, exp_drops = 0;
  int wr_cnt [4];
  logic [63:0] first_d [4];
  int wcyc2 [$];
  beat_t bq [$];
  logic [63:0] pq_d [$];
  logic [7:0]  pq_c [$];

  output_dispatcher dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data_0(od0), .out_ctrl_0(oc0), .out_wr_0(ow0), .out_rdy_0(out_rdy[0]),
    .out_data_1(od1), .out_ctrl_1(oc1), .out_wr_1(ow1), .out_rdy_1(out_rdy[1]),
    .out_data_2(od2), .out_ctrl_2(oc2), .out_wr_2(ow2), .out_rdy_2(out_rdy[2]),
    .out_data_3(od3), .out_ctrl_3(oc3), .out_wr_3(ow3), .out_rdy_3(out_rdy[3]),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clr_cnt();
    for (int k = 0; k < 4; k++) begin wr_cnt[k] = 0; first_d[k] = '0; end
    wcyc2.delete();
  endtask

  // header: bits 51:48 = destination bitmap, low byte = packet id; body words tagged by id/index
  task automatic build(input logic [3:0] m, input int nbody, input logic [7:0] hc, input logic [7:0] id);
    pq_d.delete(); pq_c.delete();
    pq_d.push_back({12'h0, m, 40'h0, id}); pq_c.push_back(hc);
    for (int i = 1; i <= nbody; i++) begin
      pq_d.push_back({id, 24'hB0D1E5, 32'(i)}); pq_c.push_back(8'h00);
    end
    pq_d.push_back({id, 24'hE0E0E0, 32'hFFFF}); pq_c.push_back(8'h08);
  endtask

  task automatic model_pkt();
    logic [63:0] h;
    h = pq_d[0];
    if (pq_c[0] == 8'hFF && h[51:48] != 4'h0) begin
      for (int i = FIRST; i < pq_d.size(); i++) bq.push_back('{h[51:48], pq_d[i], pq_c[i]});
    end else exp_drops++;
  endtask

  task automatic send(input bit mdl);
    if (mdl) model_pkt();
    for (int i = 0; i < pq_d.size(); i++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (!in_rdy && w < 3000) begin in_wr = 1'b0; @(negedge clk); w++; end
      if (!in_rdy) begin chk("in_rdy_timeout", 64'(in_rdy), 64'd1); in_wr = 1'b0; return; end
      in_wr = 1'b1; in_data = pq_d[i]; in_ctrl = pq_c[i];
    end
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (bq.size() != 0 && w < 2000) begin @(negedge clk); w++; end
    chk("drain_left", 64'(bq.size()), 64'd0);
    repeat (10) @(negedge clk);
  endtask

  // every written beat must match the next predicted beat, on exactly its port set, with ready seen
  always begin
    logic [3:0]  rdy_e, wr;
    logic [63:0] odv [4];
    logic [7:0]  ocv [4];
    beat_t b;
    @(posedge clk);
    rdy_e = out_rdy;
    #1;
    wr = {ow3, ow2, ow1, ow0};
    odv = '{od0, od1, od2, od3};
    ocv = '{oc0, oc1, oc2, oc3};
    if (reset && wr != 4'h0) begin
      if (bq.size() == 0) chk("unexpected_wr", 64'(wr), 64'd0);
      else begin
        b = bq.pop_front();
        chk("wr_mask", 64'(wr), 64'(b.m));
        for (int k = 0; k < 4; k++) if (wr[k]) begin
          chk($sformatf("data_p%0d", k), odv[k], b.d);
          chk($sformatf("ctrl_p%0d", k), 64'(ocv[k]), 64'(b.c));
          chk($sformatf("rdy_gate_p%0d", k), 64'(rdy_e[k]), 64'd1);
        end
      end
      for (int k = 0; k < 4; k++) if (wr[k]) begin
        if (wr_cnt[k] == 0) first_d[k] = odv[k];
        wr_cnt[k]++;
      end
      if (wr[2]) wcyc2.push_back(cyc);
    end
  end

  initial begin
    int c0, c3, w;
    clr_cnt();
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("rst_wr", 64'({ow3, ow2, ow1, ow0}), 64'd0);
    chk("rst_data0", od0, 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("in_rdy_after_rst", 64'(in_rdy), 64'd1);

    // unicast to port 2, back-to-back
    build(4'b0100, 3, 8'hFF, 8'h01);
    send(1'b1);
    drain();
    chk("uni_p2_cnt", 64'(wr_cnt[2]), 64'(5 - FIRST));
    chk("uni_p0_cnt", 64'(wr_cnt[0]), 64'd0);
    chk("uni_p1_cnt", 64'(wr_cnt[1]), 64'd0);
    chk("uni_p3_cnt", 64'(wr_cnt[3]), 64'd0);
    chk("uni_first_word", first_d[2], FIRST_P2);
    if (wcyc2.size() > 0) chk("uni_span", 64'(wcyc2[wcyc2.size()-1] - wcyc2[0]), 64'(4 - FIRST));

    // multicast 1011 with port 1 stalled 10 cycles mid-packet
    clr_cnt();
    build(4'b1011, 8, 8'hFF, 8'h02);
    fork
      send(1'b1);
      begin
        w = 0;
        while (wr_cnt[0] < 3 && w < 200) begin @(negedge clk); w++; end
        chk("mc_reached_mid", 64'(wr_cnt[0] >= 3), 64'd1);
        out_rdy[1] = 1'b0;
        c0 = wr_cnt[0]; c3 = wr_cnt[3];
        repeat (10) @(negedge clk);
        chk("mc_stall_p0", 64'(wr_cnt[0]), 64'(c0));
        chk("mc_stall_p3", 64'(wr_cnt[3]), 64'(c3));
        out_rdy[1] = 1'b1;
      end
    join
    drain();
    chk("mc_p0_cnt", 64'(wr_cnt[0]), 64'(10 - FIRST));
    chk("mc_p1_cnt", 64'(wr_cnt[1]), 64'(10 - FIRST));
    chk("mc_p3_cnt", 64'(wr_cnt[3]), 64'(10 - FIRST));
    chk("mc_p2_cnt", 64'(wr_cnt[2]), 64'd0);

    // two drops, then a good packet to port 1
    clr_cnt();
    build(4'b0000, 3, 8'hFF, 8'h03); send(1'b1);
    build(4'b0001, 2, 8'h02, 8'h04); send(1'b1);
    build(4'b0010, 4, 8'hFF, 8'h05); send(1'b1);
    drain();
    chk("drop_count", 64'(drop_count), 64'd2);
    chk("drop_model", 64'(drop_count), 64'(exp_drops));
    chk("drop_p1_cnt", 64'(wr_cnt[1]), 64'(6 - FIRST));
    chk("drop_other_cnt", 64'(wr_cnt[0] + wr_cnt[2] + wr_cnt[3]), 64'd0);

    // overflow: outputs blocked, 40-word packet overruns the FIFO depth
    clr_cnt();
    out_rdy = 4'h0;
    build(4'b0001, 38, 8'hFF, 8'h06);
    fork
      send(1'b1);
      begin
        w = 0;
        while (in_rdy && w < 200) begin @(negedge clk); w++; end
        chk("ovf_in_rdy_fell", 64'(in_rdy), 64'd0);
        repeat (5) @(negedge clk);
        out_rdy = 4'hF;
      end
    join
    drain();
    chk("ovf_p0_cnt", 64'(wr_cnt[0]), 64'(40 - FIRST));

    // reset mid-packet: partial packet must vanish
    out_rdy = 4'b0111;
    build(4'b1000, 6, 8'hFF, 8'h07);
    send(1'b0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("mrst_data0", od0, 64'd0);
    chk("mrst_ctrl3", 64'(oc3), 64'd0);
    chk("mrst_wr", 64'({ow3, ow2, ow1, ow0}), 64'd0);
    chk("mrst_drop", 64'(drop_count), 64'd0);
    chk("mrst_in_rdy", 64'(in_rdy), 64'd0);
    repeat (3) @(negedge clk);
    out_rdy = 4'hF;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mrst_in_rdy_after", 64'(in_rdy), 64'd1);
    clr_cnt();
    build(4'b1000, 3, 8'hFF, 8'h08);
    send(1'b1);
    drain();
    chk("post_rst_p3_cnt", 64'(wr_cnt[3]), 64'(5 - FIRST));
    chk("post_rst_other", 64'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1);
  end

endmodule
